// File: rtl/uart_verification_if.sv
// rtl/uart_verification_if.sv - pin bundle for the dual 8N1 UART loopback block
interface uart_verification_if;
    logic       rx1;
    logic       tx1;
    logic       transmit1;
    logic [7:0] tx_byte1;
    logic       received1;
    logic [7:0] rx_byte1;
    logic       is_receiving1;
    logic       is_transmitting1;
    logic       recv_error1;
    logic       tx2;
    logic       transmit2;
    logic [7:0] tx_byte2;
    logic       received2;
    logic [7:0] rx_byte2;
    logic       is_receiving2;
    logic       is_transmitting2;
    logic       recv_error2;

    modport master (
        output rx1, transmit1, tx_byte1, transmit2, tx_byte2,
        input  tx1, received1, rx_byte1, is_receiving1, is_transmitting1, recv_error1,
        input  tx2, received2, rx_byte2, is_receiving2, is_transmitting2, recv_error2
    );

    modport slave (
        input  rx1, transmit1, tx_byte1, transmit2, tx_byte2,
        output tx1, received1, rx_byte1, is_receiving1, is_transmitting1, recv_error1,
        output tx2, received2, rx_byte2, is_receiving2, is_transmitting2, recv_error2
    );
endinterface

// File: rtl/uart_verification.sv
// rtl/uart_verification.sv - two 8N1 UART channels, UART1 tx looped into UART2 rx
// One uart_channel is a complete transmitter plus receiver; the top wires two of
// them together so that every byte UART1 sends is received by UART2.
module uart_channel #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       recv_error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_STOP      = 3'd3;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    logic [2:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_meta;
    logic          rx_sync;

    // Transmitter: latch the byte on the request edge, then clock out start/data/stop bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state        <= TX_IDLE;
            tx              <= 1'b1;
            is_transmitting <= 1'b0;
            tx_cnt          <= '0;
            tx_bit          <= '0;
            tx_shift        <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (transmit) begin
                        tx_shift        <= tx_byte;
                        tx              <= 1'b0;
                        is_transmitting <= 1'b1;
                        tx_cnt          <= '0;
                        tx_state        <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx     <= tx_shift[tx_bit + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    // Dropping busy here guarantees one idle cycle before the next frame.
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt          <= '0;
                        is_transmitting <= 1'b0;
                        tx_state        <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchronizer on the serial input; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver: detect start, check it at half a bit, then sample every bit centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_byte      <= '0;
            received     <= 1'b0;
            recv_error   <= 1'b0;
            is_receiving <= 1'b0;
        end else begin
            received   <= 1'b0;
            recv_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        is_receiving <= 1'b1;
                        rx_cnt       <= '0;
                        rx_state     <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            // Line went back high before mid start bit: treat as a glitch.
                            recv_error   <= 1'b1;
                            is_receiving <= 1'b0;
                            rx_state     <= RX_IDLE;
                        end else begin
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            rx_byte      <= rx_shift;
                            received     <= 1'b1;
                            is_receiving <= 1'b0;
                            rx_state     <= RX_IDLE;
                        end else begin
                            recv_error <= 1'b1;
                            rx_state   <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A broken frame must not be mistaken for a new start bit.
                    if (rx_sync) begin
                        is_receiving <= 1'b0;
                        rx_state     <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

module uart_verification #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic                clk,
    input  logic                rst,
    uart_verification_if.slave  bus
);
    logic tx1_line;
    logic tx2_line;

    assign bus.tx1 = tx1_line;
    assign bus.tx2 = tx2_line;

    uart_channel #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart1 (
        .clk             (clk),
        .rst             (rst),
        .rx              (bus.rx1),
        .tx              (tx1_line),
        .transmit        (bus.transmit1),
        .tx_byte         (bus.tx_byte1),
        .received        (bus.received1),
        .rx_byte         (bus.rx_byte1),
        .is_receiving    (bus.is_receiving1),
        .is_transmitting (bus.is_transmitting1),
        .recv_error      (bus.recv_error1)
    );

    uart_channel #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart2 (
        .clk             (clk),
        .rst             (rst),
        .rx              (tx1_line),
        .tx              (tx2_line),
        .transmit        (bus.transmit2),
        .tx_byte         (bus.tx_byte2),
        .received        (bus.received2),
        .rx_byte         (bus.rx_byte2),
        .is_receiving    (bus.is_receiving2),
        .is_transmitting (bus.is_transmitting2),
        .recv_error      (bus.recv_error2)
    );
endmodule

// File: tb/tb_uart_verification.sv
// tb/tb_uart_verification.sv - directed self-checking bench for uart_verification
module tb_uart_verification;
    localparam int CPB = 16;

    logic clk;
    logic rst;
    logic rx1_drv;
    logic loop21;
    int   checks;
    int   errors;

    int rcv1_cnt, err1_cnt, rcv2_cnt, err2_cnt;
    int both_cnt, wide_cnt;
    logic prev_r1, prev_e1, prev_r2, prev_e2;

    uart_verification_if bus ();

    assign bus.rx1 = loop21 ? bus.tx2 : rx1_drv;

    uart_verification #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Pulse monitor: counts received/error pulses and flags overlap or stretched pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_r1 = 1'b0; prev_e1 = 1'b0; prev_r2 = 1'b0; prev_e2 = 1'b0;
        end else begin
            if (bus.received1) rcv1_cnt++;
            if (bus.recv_error1) err1_cnt++;
            if (bus.received2) rcv2_cnt++;
            if (bus.recv_error2) err2_cnt++;
            if ((bus.received1 && bus.recv_error1) || (bus.received2 && bus.recv_error2)) both_cnt++;
            if ((bus.received1 && prev_r1) || (bus.recv_error1 && prev_e1) ||
                (bus.received2 && prev_r2) || (bus.recv_error2 && prev_e2)) wide_cnt++;
            prev_r1 = bus.received1; prev_e1 = bus.recv_error1;
            prev_r2 = bus.received2; prev_e2 = bus.recv_error2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_rx1(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx1_drv = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx1_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic wait_received2(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40 * CPB; i++) begin
            @(negedge clk);
            if (bus.received2) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_recv;
        int         exp_err;
        logic [7:0] exp_rx;
    } rx_vec_t;

    rx_vec_t    vecs [7];
    logic [9:0] frame_a5;
    int         bad_bit [10];
    int         busy_bad;
    int         r0, e0;
    logic       ok;
    logic [7:0] exp_b;

    initial begin
        vecs[0] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h81, 1'b0, 0, 1, 8'hFF};
        vecs[4] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        vecs[5] = '{8'h00, 1'b0, 0, 1, 8'h3C};
        vecs[6] = '{8'h96, 1'b1, 1, 0, 8'h96};
        checks = 0; errors = 0;
        rcv1_cnt = 0; err1_cnt = 0; rcv2_cnt = 0; err2_cnt = 0;
        both_cnt = 0; wide_cnt = 0;

        rst = 1'b1; rx1_drv = 1'b1; loop21 = 1'b0;
        bus.transmit1 = 1'b0; bus.tx_byte1 = 8'h00;
        bus.transmit2 = 1'b0; bus.tx_byte2 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset tx1", bus.tx1, 1);
        check("reset tx2", bus.tx2, 1);
        check("reset flags", {bus.received1, bus.is_receiving1, bus.is_transmitting1, bus.recv_error1,
                              bus.received2, bus.is_receiving2, bus.is_transmitting2, bus.recv_error2}, 0);
        check("reset rx_byte1", bus.rx_byte1, 0);
        check("reset rx_byte2", bus.rx_byte2, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Loopback with back-to-back frames, byte bumped on each received2.
        bus.tx_byte1 = 8'h03;
        bus.transmit1 = 1'b1;
        exp_b = 8'h03;
        for (int k = 0; k < 5; k++) begin
            wait_received2(ok);
            check("loopback pulse seen", ok, 1);
            check("loopback rx_byte2", bus.rx_byte2, exp_b);
            if (k == 4) bus.transmit1 = 1'b0;
            exp_b = exp_b + 8'h01;
            bus.tx_byte1 = exp_b;
        end
        repeat (3 * CPB) @(negedge clk);
        check("loopback no recv_error2", err2_cnt, 0);
        check("loopback frame count", rcv2_cnt, 5);

        // Bit timing of a single 8'hA5 frame on tx1.
        frame_a5 = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) bad_bit[b] = 0;
        busy_bad = 0;
        bus.tx_byte1 = 8'hA5;
        bus.transmit1 = 1'b1;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            bus.transmit1 = 1'b0;
            bus.tx_byte1 = 8'h00;
            if (bus.tx1 !== frame_a5[i / CPB]) bad_bit[i / CPB]++;
            if (bus.is_transmitting1 !== 1'b1) busy_bad++;
        end
        for (int b = 0; b < 10; b++) check($sformatf("tx1 bit %0d wrong samples", b), bad_bit[b], 0);
        check("is_transmitting1 gaps", busy_bad, 0);
        @(negedge clk);
        check("is_transmitting1 after frame", bus.is_transmitting1, 0);
        check("tx1 idle after frame", bus.tx1, 1);
        repeat (2 * CPB) @(negedge clk);
        check("uart2 got A5", bus.rx_byte2, 8'hA5);

        // Table of frames driven onto rx1.
        for (int v = 0; v < 7; v++) begin
            r0 = rcv1_cnt; e0 = err1_cnt;
            send_rx1(vecs[v].data, vecs[v].stop_bit);
            check($sformatf("vec%0d received1 count", v), rcv1_cnt - r0, vecs[v].exp_recv);
            check($sformatf("vec%0d recv_error1 count", v), err1_cnt - e0, vecs[v].exp_err);
            check($sformatf("vec%0d rx_byte1", v), bus.rx_byte1, vecs[v].exp_rx);
            check($sformatf("vec%0d is_receiving1 idle", v), bus.is_receiving1, 0);
        end

        // UART2 -> UART1 via external loop.
        loop21 = 1'b1;
        r0 = rcv1_cnt;
        @(negedge clk);
        bus.tx_byte2 = 8'h5A;
        bus.transmit2 = 1'b1;
        @(negedge clk);
        bus.transmit2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 * CPB; i++) begin
            @(negedge clk);
            if (bus.received1) begin
                ok = 1'b1;
                break;
            end
        end
        check("uart2->uart1 pulse seen", ok, 1);
        check("uart2->uart1 rx_byte1", bus.rx_byte1, 8'h5A);
        repeat (2 * CPB) @(negedge clk);
        check("uart2->uart1 single pulse", rcv1_cnt - r0, 1);
        loop21 = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Start-bit glitch shorter than half a bit, then a good frame.
        r0 = rcv1_cnt; e0 = err1_cnt;
        rx1_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx1_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch recv_error1", err1_cnt - e0, 1);
        check("glitch no received1", rcv1_cnt - r0, 0);
        check("glitch receiver idle", bus.is_receiving1, 0);
        check("glitch rx_byte1 kept", bus.rx_byte1, 8'h5A);
        send_rx1(8'hC3, 1'b1);
        check("after glitch rx_byte1", bus.rx_byte1, 8'hC3);
        check("after glitch received1", rcv1_cnt - r0, 1);

        // Reset asserted mid-frame.
        bus.tx_byte1 = 8'h11;
        bus.transmit1 = 1'b1;
        @(negedge clk);
        bus.transmit1 = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("mid-frame busy before reset", bus.is_transmitting1, 1);
        rst = 1'b1;
        #1;
        check("mid-frame reset tx1", bus.tx1, 1);
        check("mid-frame reset flags", {bus.is_transmitting1, bus.is_receiving2, bus.received2, bus.recv_error2}, 0);
        check("mid-frame reset rx_byte1", bus.rx_byte1, 0);
        check("mid-frame reset rx_byte2", bus.rx_byte2, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("post-reset tx1 idle", bus.tx1, 1);
        check("post-reset no frame", {bus.is_transmitting1, bus.is_receiving2, bus.rx_byte2}, 0);

        check("received and recv_error overlap", both_cnt, 0);
        check("stretched pulses", wide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
